// File: rtl/clk_enable_sched.sv
// Per-channel programmable clock-enable strobes with phase resync.
// Define CLKEN_ALIGN_EN to defer reconfiguration to the period boundary.
module clk_enable_sched #(
   parameter int N_CH = 4,
   parameter int DIVW = 8,
   localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            cfg_valid,
   output logic            cfg_ready,
   input  logic [CW-1:0]   cfg_chan,
   input  logic [DIVW-1:0] cfg_div,
   input  logic            cfg_en,
   input  logic            resync,
   output logic [N_CH-1:0] ce,
   output logic            busy
);

   logic [DIVW-1:0] div_q [N_CH];
   logic [DIVW-1:0] cnt_q [N_CH];
   logic [N_CH-1:0] en_q;

   logic [N_CH-1:0] sel;
   logic [N_CH-1:0] ld;
   logic [N_CH-1:0] ld_ce;
   logic [DIVW-1:0] ld_div;
   logic            ld_en;

   // Out-of-range channel numbers decode to an empty select
   always_comb begin
      sel = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (cfg_chan == CW'(i)) sel[i] = 1'b1;
      end
   end

`ifdef CLKEN_ALIGN_EN
   typedef enum logic {IDLE, PEND} state_t;

   state_t          st_q, st_d;
   logic [N_CH-1:0] p_sel_q;
   logic [DIVW-1:0] p_div_q;
   logic            p_en_q;
   logic            tgt_en;
   logic            hit;

   assign tgt_en = |(sel & en_q);

   always_comb begin
      hit = 1'b0;
      for (int i = 0; i < N_CH; i++) begin
         if (p_sel_q[i] && cnt_q[i] == div_q[i]) hit = 1'b1;
      end
   end

   always_comb begin
      st_d      = st_q;
      ld        = '0;
      ld_ce     = '0;
      ld_div    = cfg_div;
      ld_en     = cfg_en;
      cfg_ready = 1'b0;
      busy      = 1'b0;
      unique case (st_q)
         IDLE: begin
            cfg_ready = 1'b1;
            if (cfg_valid && tgt_en) st_d = PEND;
            else if (cfg_valid)      ld   = sel;
         end
         PEND: begin
            busy   = 1'b1;
            ld_div = p_div_q;
            ld_en  = p_en_q;
            // Boundary apply keeps the strobe that closes the old period
            if (hit || resync) begin
               ld    = p_sel_q;
               ld_ce = hit ? p_sel_q : '0;
               st_d  = IDLE;
            end
         end
         default: st_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         st_q    <= IDLE;
         p_sel_q <= '0;
         p_div_q <= '0;
         p_en_q  <= 1'b0;
      end else begin
         st_q <= st_d;
         if (st_q == IDLE && cfg_valid && tgt_en) begin
            p_sel_q <= sel;
            p_div_q <= cfg_div;
            p_en_q  <= cfg_en;
         end
      end
   end
`else
   assign cfg_ready = 1'b1;
   assign busy      = 1'b0;

   always_comb begin
      ld     = cfg_valid ? sel : '0;
      ld_ce  = '0;
      ld_div = cfg_div;
      ld_en  = cfg_en;
   end
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         en_q <= '0;
         ce   <= '0;
         for (int i = 0; i < N_CH; i++) begin
            div_q[i] <= '0;
            cnt_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            if (ld[i]) begin
               div_q[i] <= ld_div;
               en_q[i]  <= ld_en;
               cnt_q[i] <= '0;
               ce[i]    <= ld_ce[i];
            end else if (resync || !en_q[i]) begin
               cnt_q[i] <= '0;
               ce[i]    <= 1'b0;
            end else if (cnt_q[i] == div_q[i]) begin
               cnt_q[i] <= '0;
               ce[i]    <= 1'b1;
            end else begin
               cnt_q[i] <= cnt_q[i] + DIVW'(1);
               ce[i]    <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_clk_enable_sched.sv
// Directed bench for clk_enable_sched (immediate or CLKEN_ALIGN_EN build).
// Five channels so that channel 5 is a representable invalid target.
module tb_clk_enable_sched;

   localparam int N_CH = 5;
   localparam int DIVW = 8;
   localparam int CW   = 3;
`ifdef CLKEN_ALIGN_EN
   localparam bit ALIGN = 1'b1;
`else
   localparam bit ALIGN = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            reset_n = 1'b0;
   logic            cfg_valid = 1'b0;
   logic [CW-1:0]   cfg_chan = '0;
   logic [DIVW-1:0] cfg_div = '0;
   logic            cfg_en = 1'b0;
   logic            resync = 1'b0;
   logic            cfg_ready;
   logic            busy;
   logic [N_CH-1:0] ce;

   int tests = 0;
   int fails = 0;

   clk_enable_sched #(.N_CH(N_CH), .DIVW(DIVW)) dut (
      .clk(clk),
      .reset_n(reset_n),
      .cfg_valid(cfg_valid),
      .cfg_ready(cfg_ready),
      .cfg_chan(cfg_chan),
      .cfg_div(cfg_div),
      .cfg_en(cfg_en),
      .resync(resync),
      .ce(ce),
      .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic bit exp_ce(input int k, input int d);
      return (k > 0) && (k % (d + 1) == 0);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int ch, input int dv, input bit e);
      cfg_valid = 1'b1;
      cfg_chan  = CW'(ch);
      cfg_div   = DIVW'(dv);
      cfg_en    = e;
   endtask

   task automatic do_reset();
      cfg_valid = 1'b0;
      resync    = 1'b0;
      reset_n   = 1'b0;
      repeat (3) step();
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      int bad;
      cfg_valid = 1'b0;
      reset_n   = 1'b0;
      repeat (3) step();
      tests++;
      if (ce !== '0) begin
         fails++;
         $display("FAIL reset_ce: got %b want 0", ce);
      end
      tests++;
      if (cfg_ready !== 1'b1) begin
         fails++;
         $display("FAIL reset_ready: got %b want 1", cfg_ready);
      end
      tests++;
      if (busy !== 1'b0) begin
         fails++;
         $display("FAIL reset_busy: got %b want 0", busy);
      end
      reset_n = 1'b1;
      bad = 0;
      repeat (40) begin
         step();
         if (ce !== '0) bad++;
      end
      tests++;
      if (bad !== 0) begin
         fails++;
         $display("FAIL reset_idle: %0d cycles with strobes, want 0", bad);
      end
   endtask

   task automatic test_basic();
      int off[3]   = '{0, 1, 2};
      int dv[3]    = '{0, 3, 255};
      int want[3]  = '{1, 5, 258};
      int first[3] = '{-1, -1, -1};
      int errs[3]  = '{0, 0, 0};
      int other    = 0;
      do_reset();
      for (int k = 0; k <= 600; k++) begin
         if (k == 0)      drive(0, 0, 1'b1);
         else if (k == 1) drive(1, 3, 1'b1);
         else if (k == 2) drive(2, 255, 1'b1);
         else             cfg_valid = 1'b0;
         step();
         for (int c = 0; c < 3; c++) begin
            if (ce[c] !== exp_ce(k - off[c], dv[c])) errs[c]++;
            if (ce[c] === 1'b1 && first[c] < 0) first[c] = k;
         end
         if (ce[4:3] !== 2'b00) other++;
      end
      for (int c = 0; c < 3; c++) begin
         tests++;
         if (errs[c] !== 0) begin
            fails++;
            $display("FAIL basic_pattern ch%0d: %0d bad cycles, want 0",
                     c, errs[c]);
         end
         tests++;
         if (first[c] !== want[c]) begin
            fails++;
            $display("FAIL basic_first ch%0d: got cycle %0d want %0d",
                     c, first[c], want[c]);
         end
      end
      tests++;
      if (other !== 0) begin
         fails++;
         $display("FAIL basic_idle_ch: %0d bad cycles, want 0", other);
      end
   endtask

   task automatic test_resync();
      int errs = 0;
      do_reset();
      drive(1, 3, 1'b1);
      step();
      cfg_valid = 1'b0;
      step();
      drive(3, 3, 1'b1);
      step();
      cfg_valid = 1'b0;
      step();
      step();
      tests++;
      if ({ce[1], ce[3]} !== 2'b10) begin
         fails++;
         $display("FAIL resync_pre_a: got %b%b want 10", ce[1], ce[3]);
      end
      step();
      step();
      tests++;
      if ({ce[1], ce[3]} !== 2'b01) begin
         fails++;
         $display("FAIL resync_pre_b: got %b%b want 01", ce[1], ce[3]);
      end
      step();
      resync = 1'b1;
      step();
      resync = 1'b0;
      tests++;
      if ({ce[1], ce[3]} !== 2'b00) begin
         fails++;
         $display("FAIL resync_edge: got %b%b want 00", ce[1], ce[3]);
      end
      for (int k = 1; k <= 16; k++) begin
         step();
         if (ce[1] !== (k % 4 == 0)) errs++;
         if (ce[3] !== (k % 4 == 0)) errs++;
      end
      tests++;
      if (errs !== 0) begin
         fails++;
         $display("FAIL resync_align: %0d bad samples, want 0", errs);
      end
   endtask

   task automatic test_reconfig();
      int n = 0;
      int e_ce = 0;
      int e_bs = 0;
      int e_rd = 0;
      int nbusy = 0;
      bit xc, xb;
      do_reset();
      drive(1, 7, 1'b1);
      step();
      cfg_valid = 1'b0;
      while (ce[1] !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      tests++;
      if (n !== 8) begin
         fails++;
         $display("FAIL reconf_first: got cycle %0d want 8", n);
      end
      step();
      drive(1, 1, 1'b1);
      for (int k = 2; k <= 14; k++) begin
         step();
         cfg_valid = 1'b0;
         xc = ALIGN ? (k >= 8 && k % 2 == 0) : (k >= 4 && k % 2 == 0);
         xb = ALIGN && k >= 2 && k <= 7;
         if (ce[1] !== xc) e_ce++;
         if (busy !== xb) e_bs++;
         if (cfg_ready !== !xb) e_rd++;
         if (busy === 1'b1) nbusy++;
      end
      tests++;
      if (e_ce !== 0) begin
         fails++;
         $display("FAIL reconf_ce: %0d bad cycles, want 0", e_ce);
      end
      tests++;
      if (e_bs !== 0) begin
         fails++;
         $display("FAIL reconf_busy: %0d bad cycles, want 0", e_bs);
      end
      tests++;
      if (e_rd !== 0) begin
         fails++;
         $display("FAIL reconf_ready: %0d bad cycles, want 0", e_rd);
      end
      tests++;
      if (nbusy !== (ALIGN ? 6 : 0)) begin
         fails++;
         $display("FAIL reconf_busy_len: got %0d want %0d",
                  nbusy, ALIGN ? 6 : 0);
      end
   endtask

   task automatic test_invalid_chan();
      int errs = 0;
      do_reset();
      drive(0, 2, 1'b1);
      step();
      drive(5, 0, 1'b1);
      tests++;
      if (cfg_ready !== 1'b1) begin
         fails++;
         $display("FAIL inval_ready: got %b want 1", cfg_ready);
      end
      step();
      cfg_valid = 1'b0;
      tests++;
      if ({cfg_ready, busy} !== 2'b10) begin
         fails++;
         $display("FAIL inval_state: ready/busy %b%b want 10",
                  cfg_ready, busy);
      end
      if (ce !== {4'b0, exp_ce(1, 2)}) errs++;
      for (int k = 2; k <= 13; k++) begin
         step();
         if (ce !== {4'b0, exp_ce(k, 2)}) errs++;
      end
      tests++;
      if (errs !== 0) begin
         fails++;
         $display("FAIL inval_pattern: %0d bad cycles, want 0", errs);
      end
   endtask

   task automatic test_disable();
      int errs = 0;
      do_reset();
      drive(2, 3, 1'b1);
      step();
      cfg_valid = 1'b0;
      repeat (4) step();
      tests++;
      if (ce[2] !== 1'b1) begin
         fails++;
         $display("FAIL dis_pre: got %b want 1", ce[2]);
      end
      drive(2, 3, 1'b0);
      for (int k = 5; k <= 30; k++) begin
         step();
         cfg_valid = 1'b0;
         if (ce[2] !== (ALIGN && k == 8)) errs++;
      end
      tests++;
      if (errs !== 0) begin
         fails++;
         $display("FAIL dis_pattern: %0d bad cycles, want 0", errs);
      end
      tests++;
      if ({cfg_ready, busy} !== 2'b10) begin
         fails++;
         $display("FAIL dis_idle: ready/busy %b%b want 10", cfg_ready, busy);
      end
   endtask

   task automatic test_reset_pend();
      int bad = 0;
      do_reset();
      drive(0, 0, 1'b1);
      step();
      drive(1, 7, 1'b1);
      step();
      drive(1, 3, 1'b1);
      step();
      cfg_valid = 1'b0;
      tests++;
      if (ce[0] !== 1'b1) begin
         fails++;
         $display("FAIL rpend_ce0: got %b want 1", ce[0]);
      end
      tests++;
      if ({cfg_ready, busy} !== {!ALIGN, ALIGN}) begin
         fails++;
         $display("FAIL rpend_state: ready/busy %b%b want %b%b",
                  cfg_ready, busy, !ALIGN, ALIGN);
      end
      #2;
      reset_n = 1'b0;
      #1;
      tests++;
      if ({cfg_ready, busy, ce} !== {2'b10, 5'b0}) begin
         fails++;
         $display("FAIL rpend_async: ready/busy/ce %b%b%b want 1000000",
                  cfg_ready, busy, ce);
      end
      step();
      reset_n = 1'b1;
      repeat (10) begin
         step();
         if (ce !== '0 || cfg_ready !== 1'b1) bad++;
      end
      tests++;
      if (bad !== 0) begin
         fails++;
         $display("FAIL rpend_after: %0d bad cycles, want 0", bad);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_resync();
      test_reconfig();
      test_invalid_chan();
      test_disable();
      test_reset_pend();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
